systolic_output_deskew: RTL and testbench
=========================================

SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

Interface
REQ-001 Parameter N_LANES, 32, number of array columns / result lanes.
REQ-002 Parameter ACC_W, 32, width of one partial-sum lane.
REQ-003 Parameter ADDR_W, 10, accumulator-buffer row address width.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk_i and rst_ni.
REQ-005 clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  one-cycle pulse, begin a tile.
REQ-008 num_rows_i  in  ADDR_W  result rows in the tile, sampled with start_i.
REQ-009 base_addr_i  in  ADDR_W  first accumulator row address, sampled with start_i.
REQ-010 valid_i  in  1  lane-0 result valid; lane i is valid i cycles after lane 0.
REQ-011 data_i  in  N_LANES x ACC_W  skewed partial sums from the array bottom edge.
REQ-012 wr_en_o  out  1  accumulator write strobe.
REQ-013 wr_addr_o  out  ADDR_W  accumulator write row address.
REQ-014 wr_data_o  out  N_LANES x ACC_W  de-skewed row.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  1  one-cycle pulse when the tile's last row is written.

Function
REQ-017 Lane i SHALL pass through a delay of (N_LANES-1-i) registers, then one shared output register, so every lane of a row reaches wr_data_o together.
REQ-018 A 1-bit valid delay line of depth N_LANES-1, plus the output register, SHALL track valid_i. wr_en_o SHALL assert exactly N_LANES cycles after the accepted valid_i (32 cycles at the default).
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start_i latches num_rows_i and base_addr_i, clears both counters, and moves to RUN. If num_rows_i==0, it moves to DONE instead.
REQ-021 RUN: each valid_i increments in_cnt. When the incremented value equals num_rows, the FSM moves to DRAIN.
REQ-022 DRAIN: the FSM waits until out_cnt equals num_rows, then moves to DONE.
REQ-023 DONE: done_o is high for exactly this one cycle, then the FSM returns to IDLE.
REQ-024 valid_i SHALL be accepted into the delay line only in RUN. In IDLE, DRAIN and DONE it is ignored: no write and no count.
REQ-025 start_i SHALL be ignored outside IDLE.
REQ-026 Each wr_en_o SHALL use wr_addr_o = base_addr + out_cnt, modulo 2^ADDR_W (wrap-around allowed), then increment out_cnt.
REQ-027 Back-to-back valid_i on consecutive cycles SHALL produce back-to-back writes at consecutive addresses, with no bubbles.
REQ-028 wr_data_o SHALL hold its last written value when wr_en_o is low. Consumers use it only when wr_en_o is high.
REQ-029 Delayed data of lanes whose valid is not asserted SHALL NOT affect counters or wr_en_o.

Reset
REQ-030 Reset asserted SHALL force: FSM to IDLE; in_cnt, out_cnt, num_rows and base_addr to 0; all valid-delay bits to 0; wr_en_o=0, wr_addr_o=0, busy_o=0, done_o=0, wr_data_o all 0.
REQ-031 Data delay registers SHALL be cleared by reset.
REQ-032 Reset during RUN or DRAIN SHALL abandon the tile: no write, and no done_o, after reset is released.
REQ-033 Reset deassertion SHALL be synchronised externally. The block needs no extra settling cycle.

Structure
REQ-034 N_LANES, ACC_W, ADDR_W and the FSM state enum SHALL live in the shared tpu_pkg package.
REQ-035 The per-lane delay SHALL be one parameterised sub-module, skew_delay_line (parameters DEPTH and WIDTH; DEPTH=0 is a wire).
REQ-036 The design SHALL be fully synchronous to clk_i, with no latches and no combinational path from inputs to outputs.

Verification
REQ-037 Single row: start_i with num_rows=1, base=5; valid_i at cycle T with lane i = i+1, each lane skewed i cycles. Expect one write at T+32, addr 5, wr_data[i]=i+1, then done_o on the next cycle.
REQ-038 Burst: num_rows=4, base=0; valid_i on 4 consecutive cycles with row r lane i = 100*r+i. Expect writes at addrs 0,1,2,3 on consecutive cycles with matching data, then done_o once.
REQ-039 Wrap: base=1022, num_rows=4, ADDR_W=10. Expect addresses 1022, 1023, 0, 1.
REQ-040 Zero rows and ignored inputs: num_rows=0 gives done_o one cycle after start with no write. A start_i pulse during RUN and a valid_i in IDLE both produce no effect.
REQ-041 Reset mid-tile: rst_ni low for 2 cycles during DRAIN. Expect all outputs 0 immediately, no later wr_en_o/done_o, and a fresh tile afterwards behaving as in REQ-037.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array output path.
// Holds the default array geometry (lane count, partial-sum width, accumulator
// address width) and the de-skew controller state encoding.
package tpu_pkg;

    localparam int N_LANES = 32;
    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } deskew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register delay line used to re-align one systolic lane.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - WIDTH-bit input sample
//   q_o    - d_i delayed by DEPTH clock cycles (DEPTH=0 is a plain wire)
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_reg
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;
            logic [DEPTH-1:0][WIDTH-1:0] stage_d;

            // Next-stage values: stage 0 takes the input, every other stage its predecessor.
            always_comb begin
                stage_d    = stage_q;
                stage_d[0] = d_i;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_d[k] = stage_q[k-1];
                end
            end

            // Shift register state.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_output_deskew.sv
// De-skews the bottom edge of a systolic array into whole accumulator rows.
// Lane i arrives i cycles after lane 0; each lane is delayed by the remaining
// (N_LANES-1-i) cycles so a full row lands in the output register together,
// N_LANES cycles after the lane-0 valid. A small controller counts rows in and
// out of a tile and generates accumulator write addresses.
// Ports:
//   clk_i, rst_ni             - clock / asynchronous active-low reset
//   start_i                   - tile start pulse (IDLE only)
//   num_rows_i, base_addr_i   - tile row count and first row address, sampled with start_i
//   valid_i, data_i           - skewed lane-0 valid and per-lane partial sums
//   wr_en_o, wr_addr_o,
//   wr_data_o                 - registered accumulator write port
//   busy_o, done_o            - not-IDLE flag and end-of-tile pulse
module systolic_output_deskew #(
    parameter int N_LANES = tpu_pkg::N_LANES,
    parameter int ACC_W   = tpu_pkg::ACC_W,
    parameter int ADDR_W  = tpu_pkg::ADDR_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [ADDR_W-1:0]               num_rows_i,
    input  logic [ADDR_W-1:0]               base_addr_i,
    input  logic                            valid_i,
    input  logic [N_LANES-1:0][ACC_W-1:0]   data_i,
    output logic                            wr_en_o,
    output logic [ADDR_W-1:0]               wr_addr_o,
    output logic [N_LANES-1:0][ACC_W-1:0]   wr_data_o,
    output logic                            busy_o,
    output logic                            done_o
);

    import tpu_pkg::deskew_state_e;
    import tpu_pkg::ST_IDLE;
    import tpu_pkg::ST_RUN;
    import tpu_pkg::ST_DRAIN;
    import tpu_pkg::ST_DONE;

    deskew_state_e                   state_q, state_d;
    logic [ADDR_W-1:0]               in_cnt_q, in_cnt_d;
    logic [ADDR_W-1:0]               out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0]               num_rows_q, num_rows_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic                            wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]               wr_addr_q, wr_addr_d;
    logic [N_LANES-1:0][ACC_W-1:0]   wr_data_q, wr_data_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic                            valid_acc_s;
    logic                            wr_fire_s;
    logic [ADDR_W-1:0]               in_cnt_inc_s;
    logic [N_LANES-1:0][ACC_W-1:0]   lane_dly_s;

    // Only rows arriving while RUN enter the pipeline; anything else is dropped here.
    assign valid_acc_s  = valid_i & (state_q == ST_RUN);
    assign in_cnt_inc_s = in_cnt_q + ADDR_W'(1);

    // Per-lane alignment. The last lane already arrives latest, so it needs no delay.
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        if (i == N_LANES - 1) begin : g_last
            assign lane_dly_s[i] = data_i[i];
        end else begin : g_dly
            skew_delay_line #(
                .DEPTH (N_LANES - 1 - i),
                .WIDTH (ACC_W)
            ) u_dly (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .d_i    (data_i[i]),
                .q_o    (lane_dly_s[i])
            );
        end
    end

    // Valid travels alongside lane 0's delay so it marks when the full row is aligned.
    skew_delay_line #(
        .DEPTH (N_LANES - 1),
        .WIDTH (1)
    ) u_vld_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (valid_acc_s),
        .q_o    (wr_fire_s)
    );

    // Controller next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        num_rows_d = num_rows_q;
        base_d     = base_q;

        if (wr_fire_s) begin
            out_cnt_d = out_cnt_q + ADDR_W'(1);
        end else begin
            out_cnt_d = out_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_rows_d = num_rows_i;
                    base_d     = base_addr_i;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    if (num_rows_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_i) begin
                    in_cnt_d = in_cnt_inc_s;
                    if (in_cnt_inc_s == num_rows_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // out_cnt_q already includes the write registered on the previous edge.
                if (out_cnt_q == num_rows_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_en_d = wr_fire_s;
        if (wr_fire_s) begin
            wr_addr_d = base_q + out_cnt_q;
            wr_data_d = lane_dly_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            num_rows_q <= '0;
            base_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            num_rows_q <= num_rows_d;
            base_q     <= base_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Randomised bench for systolic_output_deskew. Stimulus drives skewed rows;
// a tile-level model predicts every accumulator write (cycle, address, row),
// the done pulse and the busy window, and a negedge monitor compares.
module tb_systolic_output_deskew;

    localparam int NL = 32;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef logic [NL-1:0][DW-1:0] row_t;
    typedef struct {
        int          due;
        logic [AW-1:0] addr;
        row_t        data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [AW-1:0]   num_rows_i;
    logic [AW-1:0]   base_addr_i;
    logic            valid_i;
    row_t            data_i;
    logic            wr_en_o;
    logic [AW-1:0]   wr_addr_o;
    row_t            wr_data_o;
    logic            busy_o;
    logic            done_o;

    systolic_output_deskew dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .base_addr_i (base_addr_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Tile-level model state.
    wr_t         exp_q[$];
    int          idle_from  = 0;
    int          busy_from  = 0;
    int          run_from   = 0;
    int          done_at    = -1;
    bit          run_open   = 1'b0;
    int          rows_total = 0;
    int          acc        = 0;
    logic [AW-1:0] m_base   = '0;
    row_t        last_row   = '0;
    row_t        hist[64];
    bit          hist_v[64];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < NL; i++) r[i] = $urandom;
        return r;
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        bit  exp_wr;
        wr_t w;
        exp_wr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_eq("wr_en", wr_en_o, exp_wr);
        if (exp_wr) begin
            w = exp_q.pop_front();
            if (wr_en_o) begin
                check_eq("wr_addr", wr_addr_o, w.addr);
                for (int i = 0; i < NL; i++) check_eq("wr_data", wr_data_o[i], w.data[i]);
                last_row = w.data;
            end
        end else if (!wr_en_o) begin
            check_eq("hold_lane0", wr_data_o[0], last_row[0]);
            check_eq("hold_lastlane", wr_data_o[NL-1], last_row[NL-1]);
        end
        check_eq("done", done_o, (cyc == done_at));
        check_eq("busy", busy_o, (cyc >= busy_from) && (cyc < idle_from));
    end

    // One clock of stimulus plus the model's view of what it causes.
    task automatic drive_cycle(input bit st, input int n, input int base, input bit v, input row_t row);
        int  c;
        wr_t w;
        @(posedge clk);
        #1;
        c           = cyc;
        start_i     = st;
        num_rows_i  = n[AW-1:0];
        base_addr_i = base[AW-1:0];
        valid_i     = v;
        hist[c % 64]   = row;
        hist_v[c % 64] = v;
        for (int i = 0; i < NL; i++) begin
            if ((c - i >= 0) && hist_v[(c - i) % 64]) data_i[i] = hist[(c - i) % 64][i];
            else data_i[i] = $urandom;
        end
        if (st && (c >= idle_from)) begin
            if (n == 0) begin
                run_open  = 1'b0;
                busy_from = c + 1;
                done_at   = c + 1;
                idle_from = c + 2;
            end else begin
                rows_total = n;
                acc        = 0;
                m_base     = base[AW-1:0];
                run_open   = 1'b1;
                run_from   = c + 1;
                busy_from  = c + 1;
                idle_from  = 1 << 30;
                done_at    = -1;
            end
        end
        if (v && run_open && (c >= run_from)) begin
            w.due  = c + NL;
            w.addr = m_base + acc[AW-1:0];
            w.data = row;
            exp_q.push_back(w);
            acc++;
            if (acc == rows_total) begin
                run_open  = 1'b0;
                done_at   = c + NL + 1;
                idle_from = c + NL + 2;
            end
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 0, 0, 1'b0, rand_row());
    endtask

    // pat: 1 -> lane i = i+1, 2 -> lane i = 100*r+i, other -> random.
    // noise adds a valid in the start cycle, stray starts in gaps and a valid after done.
    task automatic tile(input int n, input int base, input int pat, input int gap_max,
                        input bit noise, input bit wait_end);
        row_t row;
        int   k;
        drive_cycle(1'b1, n, base, noise, rand_row());
        for (int r = 0; r < n; r++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int j = 0; j < g; j++)
                drive_cycle(noise && ($urandom_range(0, 1) == 1), $urandom_range(1, 9),
                            $urandom, 1'b0, rand_row());
            for (int i = 0; i < NL; i++) begin
                if (pat == 1) row[i] = i + 1;
                else if (pat == 2) row[i] = 100 * r + i;
                else row[i] = $urandom;
            end
            drive_cycle(1'b0, 0, 0, 1'b1, row);
        end
        if (wait_end) begin
            k = 0;
            while ((cyc < idle_from) && (k < 300)) begin
                idle_cycle();
                k++;
            end
            if (k >= 300) check_eq("idle_timeout", cyc, idle_from);
            if (noise) drive_cycle(1'b0, 0, 0, 1'b1, rand_row());
            idle_cycle();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_wr_en"}, wr_en_o, 1'b0);
        check_eq({tag, "_wr_addr"}, wr_addr_o, '0);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_done"}, done_o, 1'b0);
        for (int i = 0; i < NL; i++) check_eq({tag, "_wr_data"}, wr_data_o[i], '0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        exp_q.delete();
        run_open  = 1'b0;
        done_at   = -1;
        busy_from = 0;
        idle_from = 0;
        last_row  = '0;
        for (int i = 0; i < 64; i++) hist_v[i] = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        num_rows_i  = '0;
        base_addr_i = '0;
        valid_i     = 1'b0;
        data_i      = '0;
        for (int i = 0; i < 64; i++) hist_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_ni = 1'b1;

        tile(1, 5, 1, 0, 1'b0, 1'b1);          // single row
        tile(4, 0, 2, 0, 1'b0, 1'b1);          // back-to-back burst
        tile(4, 1022, 0, 0, 1'b0, 1'b1);       // address wrap
        tile(0, 7, 0, 0, 1'b1, 1'b1);          // zero rows, valid in IDLE
        tile(5, 300, 0, 2, 1'b1, 1'b1);        // gaps, stray starts during RUN

        tile(3, 40, 0, 0, 1'b0, 1'b0);         // abandon in DRAIN
        repeat (5) idle_cycle();
        reset_pulse();
        repeat (40) idle_cycle();
        tile(1, 5, 1, 0, 1'b0, 1'b1);

        for (int t = 0; t < 6; t++)
            tile($urandom_range(1, 8), $urandom_range(0, 1023), 0, $urandom_range(0, 3), 1'b1, 1'b1);

        repeat (5) idle_cycle();
        check_eq("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
